// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, single-outstanding inst-SRAM read,
// one-entry fetch buffer toward decode, and delayed-branch redirect.
// Optional feature macro FS_ADEF_EN: misaligned fetch addresses issue no SRAM
// request and deliver an address-error marker (bus widens to 65 bits).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
`ifdef FS_ADEF_EN
    output logic [64:0] fs_to_ds_bus,
`else
    output logic [63:0] fs_to_ds_bus,
`endif
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_req_pc;
    logic              r_req_tgt;

    logic              r_fs_valid;
    logic [PC_W-1:0]   r_fs_inst;
    logic [PC_W-1:0]   r_fs_pc;
`ifdef FS_ADEF_EN
    logic              r_fs_adef;
`endif

    logic              r_br_pend;
    logic              r_slot_done;
    logic [PC_W-1:0]   r_br_target;
    logic              r_cancel;

    logic              w_br_acc;
    logic              w_fs_leave;
    logic              w_issue_ok;
    logic              w_use_tgt;
    logic [PC_W-1:0]   w_issue_addr;
    logic              w_misalign;
    logic              w_issue;
    logic              w_sram_issue;
    logic              w_adef_issue;
    logic              w_req;
    logic [PC_W-1:0]   w_addr;
    logic              w_hs;
    logic              w_accept;
    logic              w_acc_tgt;
    logic              w_kill_now;
    logic              w_ret;
    logic              w_land_sram;
    logic              w_land_adef;
    logic              w_land;
    logic [PC_W-1:0]   w_bus_pc;

    // Control decode shared by the FSM and the datapath registers
    always_comb begin
        w_br_acc     = br_bus[32] & ds_allowin;
        w_fs_leave   = r_fs_valid & ds_allowin;
        w_issue_ok   = !r_fs_valid | ds_allowin;
        w_use_tgt    = r_br_pend & r_slot_done;
        w_issue_addr = w_use_tgt ? r_br_target : r_fetch_pc;
`ifdef FS_ADEF_EN
        w_misalign   = |w_issue_addr[1:0];
`else
        w_misalign   = 1'b0;
`endif
        w_issue      = (r_state == S_IDLE) & w_issue_ok & !reset;
        w_sram_issue = w_issue & !w_misalign;
        w_adef_issue = w_issue & w_misalign;
        w_hs         = w_req & inst_sram_addr_ok;
        w_accept     = w_hs | w_adef_issue;
        w_acc_tgt    = (r_state == S_IDLE) ? w_use_tgt : r_req_tgt;
        // A branch leaving decode while its slot leaves fetch kills anything younger
        w_kill_now   = w_br_acc & r_fs_valid;
        w_ret        = (r_state == S_WAIT) & inst_sram_data_ok;
        w_land_sram  = w_ret & !r_cancel & !w_kill_now;
        w_land_adef  = w_adef_issue & !w_kill_now;
        w_land       = w_land_sram | w_land_adef;
    end

    // Transaction FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Transaction FSM next state and SRAM request outputs
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_req_pc;
        case (r_state)
            S_IDLE: begin
                w_req  = w_sram_issue;
                w_addr = w_issue_addr;
                if (w_sram_issue)
                    w_state_nxt = inst_sram_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                if (inst_sram_addr_ok) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        inst_sram_req  = w_req;
        inst_sram_addr = w_addr;
    end

    // Sequential PC and the address/source of the transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_req_tgt  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_pc  <= w_issue_addr;
                r_req_tgt <= w_use_tgt;
            end
            if (w_accept) r_fetch_pc <= w_addr + PC_W'(4);
        end
    end

    // Fetch buffer: load on a surviving return, drain when decode takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_inst  <= '0;
            r_fs_pc    <= '0;
`ifdef FS_ADEF_EN
            r_fs_adef  <= 1'b0;
`endif
        end else if (w_land_sram) begin
            r_fs_valid <= 1'b1;
            r_fs_inst  <= inst_sram_rdata;
            r_fs_pc    <= r_req_pc;
`ifdef FS_ADEF_EN
            r_fs_adef  <= 1'b0;
`endif
        end else if (w_land_adef) begin
            r_fs_valid <= 1'b1;
            r_fs_inst  <= '0;
            r_fs_pc    <= w_issue_addr;
`ifdef FS_ADEF_EN
            r_fs_adef  <= 1'b1;
`endif
        end else if (w_fs_leave) begin
            r_fs_valid <= 1'b0;
        end
    end

    // Redirect tracking: target waits until the delay slot has been fetched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_pend   <= 1'b0;
            r_slot_done <= 1'b0;
            r_br_target <= '0;
        end else begin
            if (w_accept & w_acc_tgt) begin
                r_br_pend   <= 1'b0;
                r_slot_done <= 1'b0;
            end else if (r_br_pend & !r_slot_done & w_land) begin
                r_slot_done <= 1'b1;
            end
            if (w_br_acc) begin
                r_br_pend   <= 1'b1;
                r_br_target <= br_bus[31:0];
                r_slot_done <= r_fs_valid | w_land;
            end
        end
    end

    // Cancel flag: the in-flight SRAM read is past the delay slot
    always_ff @(posedge clk) begin
        if (reset)
            r_cancel <= 1'b0;
        else if (w_ret)
            r_cancel <= 1'b0;
        else if (w_kill_now & ((r_state != S_IDLE) | w_sram_issue))
            r_cancel <= 1'b1;
    end

    // Decode-facing bus; pc tracks the next instruction decode will see
    always_comb begin
        if (r_fs_valid)
            w_bus_pc = r_fs_pc;
        else if ((r_state != S_IDLE) & !r_cancel)
            w_bus_pc = r_req_pc;
        else
            w_bus_pc = r_fetch_pc;
        fs_to_ds_valid = r_fs_valid;
`ifdef FS_ADEF_EN
        fs_to_ds_bus   = {r_fs_adef, r_fs_inst, w_bus_pc};
`else
        fs_to_ds_bus   = {r_fs_inst, w_bus_pc};
`endif
    end

endmodule
